// File: rtl/bus_err_drain_arb.sv
// Round-robin drain of per-unit bus error FIFOs into one report stream.
// Holds one captured report until accepted and keeps saturating per-unit drain counts.
`timescale 1ns/1ps

module bus_err_drain_arb_cnt #(
   parameter int unsigned CntWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                inc_i,
   output logic [CntWidth-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clear_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {CntWidth{1'b1}})) begin
         cnt_o <= cnt_o + CntWidth'(1);
      end
   end

endmodule

module bus_err_drain_arb #(
   parameter int unsigned NumUnits      = 4,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned MetaDataWidth = 1,
   parameter int unsigned ErrBits       = 3,
   parameter int unsigned CntWidth      = 8,
   localparam int unsigned IdxW         = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         enable_i,
   input  logic [NumUnits-1:0]                          unit_err_irq_i,
   input  logic [NumUnits-1:0][ErrBits-1:0]             unit_err_code_i,
   input  logic [NumUnits-1:0][AddrWidth-1:0]           unit_err_addr_i,
   input  logic [NumUnits-1:0][MetaDataWidth-1:0]       unit_err_meta_i,
   input  logic [NumUnits-1:0]                          unit_err_overflow_i,
   output logic [NumUnits-1:0]                          unit_err_pop_o,
   output logic                                         rpt_valid_o,
   input  logic                                         rpt_ready_i,
   output logic [IdxW-1:0]                              rpt_unit_o,
   output logic [ErrBits-1:0]                           rpt_code_o,
   output logic [AddrWidth-1:0]                         rpt_addr_o,
   output logic [MetaDataWidth-1:0]                     rpt_meta_o,
   output logic                                         rpt_overflow_o,
   input  logic                                         cnt_clear_i,
   output logic [NumUnits-1:0][CntWidth-1:0]            err_cnt_o,
   output logic                                         irq_o
);

   typedef enum logic {Idle, Valid} state_e;

   typedef struct packed {
      logic [IdxW-1:0]          unit;
      logic [ErrBits-1:0]       code;
      logic [AddrWidth-1:0]     addr;
      logic [MetaDataWidth-1:0] meta;
      logic                     ovf;
   } rpt_t;

   state_e          state_q, state_d;
   rpt_t            rpt_q, rpt_d;
   logic [IdxW-1:0] last_q, sel, cand_idx;
   logic            any_hit, grant;
   int              cand;

   // Search begins one past the last winner, wrapping once around the ring.
   always_comb begin
      sel      = last_q;
      any_hit  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < int'(NumUnits); k++) begin
         cand = int'(last_q) + 1 + k;
         if (cand >= int'(NumUnits)) cand = cand - int'(NumUnits);
         cand_idx = cand[IdxW-1:0];
         if (!any_hit && unit_err_irq_i[cand_idx]) begin
            sel     = cand_idx;
            any_hit = 1'b1;
         end
      end
   end

   // rst_ni gating keeps pops quiet while reset is held.
   assign grant = rst_ni & enable_i & any_hit & ((state_q == Idle) | rpt_ready_i);

   always_comb begin
      unit_err_pop_o = '0;
      if (grant) unit_err_pop_o[sel] = 1'b1;
   end

   always_comb begin
      rpt_d.unit = sel;
      rpt_d.code = unit_err_code_i[sel];
      rpt_d.addr = unit_err_addr_i[sel];
      rpt_d.meta = unit_err_meta_i[sel];
      rpt_d.ovf  = unit_err_overflow_i[sel];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         Idle:    if (grant) state_d = Valid;
         Valid:   if (rpt_ready_i) state_d = grant ? Valid : Idle;
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         rpt_q   <= '0;
         last_q  <= IdxW'(NumUnits - 1);
      end else begin
         state_q <= state_d;
         if (grant) begin
            rpt_q  <= rpt_d;
            last_q <= sel;
         end
      end
   end

   assign rpt_valid_o    = (state_q == Valid);
   assign irq_o          = rpt_valid_o;
   assign rpt_unit_o     = rpt_q.unit;
   assign rpt_code_o     = rpt_q.code;
   assign rpt_addr_o     = rpt_q.addr;
   assign rpt_meta_o     = rpt_q.meta;
   assign rpt_overflow_o = rpt_q.ovf;

   for (genvar i = 0; i < NumUnits; i++) begin : g_cnt
      bus_err_drain_arb_cnt #(.CntWidth(CntWidth)) u_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (cnt_clear_i),
         .inc_i   (unit_err_pop_o[i]),
         .cnt_o   (err_cnt_o[i])
      );
   end

endmodule

// File: tb/tb_bus_err_drain_arb.sv
// Bench for bus_err_drain_arb: directed scenarios plus random traffic against a
// queue-free behavioural model of the drain arbiter.
`timescale 1ns/1ps

module tb_bus_err_drain_arb;

   localparam int N = 4;
   localparam int CW = 2;

   logic              clk_i, rst_ni, enable_i, rpt_ready_i, cnt_clear_i;
   logic [N-1:0]      irq, ovf, pop;
   logic [N-1:0][2:0] code;
   logic [N-1:0][47:0] addr;
   logic [N-1:0][0:0] meta;
   logic              rpt_valid, rpt_ovf, irq_o;
   logic [1:0]        rpt_unit;
   logic [2:0]        rpt_code;
   logic [47:0]       rpt_addr;
   logic [0:0]        rpt_meta;
   logic [N-1:0][CW-1:0] err_cnt;

   bus_err_drain_arb #(.NumUnits(N), .AddrWidth(48), .MetaDataWidth(1),
                       .ErrBits(3), .CntWidth(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
      .unit_err_irq_i(irq), .unit_err_code_i(code), .unit_err_addr_i(addr),
      .unit_err_meta_i(meta), .unit_err_overflow_i(ovf), .unit_err_pop_o(pop),
      .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready_i), .rpt_unit_o(rpt_unit),
      .rpt_code_o(rpt_code), .rpt_addr_o(rpt_addr), .rpt_meta_o(rpt_meta),
      .rpt_overflow_o(rpt_ovf), .cnt_clear_i(cnt_clear_i), .err_cnt_o(err_cnt),
      .irq_o(irq_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: one held report, a last-winner index and saturating counts.
   bit          m_vld;
   int          m_last, m_unit, m_code, m_grant;
   logic [47:0] m_addr;
   bit          m_meta, m_ovf;
   int          m_cnt[N];

   function automatic void model_reset();
      m_vld = 0; m_last = N - 1; m_unit = 0; m_code = 0; m_addr = '0;
      m_meta = 0; m_ovf = 0; m_grant = -1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endfunction

   function automatic int pick();
      for (int k = 1; k <= N; k++) begin
         int u;
         u = (m_last + k) % N;
         if (irq[u[1:0]]) return u;
      end
      return -1;
   endfunction

   task automatic settle();
      logic [N-1:0] exp_pop;
      #2;
      m_grant = (enable_i && (!m_vld || rpt_ready_i)) ? pick() : -1;
      exp_pop = '0;
      if (m_grant >= 0) exp_pop = 4'(1 << m_grant);
      chk("pop", 64'(pop), 64'(exp_pop));
      chk("valid", 64'(rpt_valid), 64'(m_vld));
      chk("irq_o", 64'(irq_o), 64'(m_vld));
      chk("unit", 64'(rpt_unit), 64'(m_unit));
      chk("code", 64'(rpt_code), 64'(m_code));
      chk("addr", 64'(rpt_addr), 64'(m_addr));
      chk("meta", 64'(rpt_meta), 64'(m_meta));
      chk("ovf", 64'(rpt_ovf), 64'(m_ovf));
      for (int i = 0; i < N; i++) chk("cnt", 64'(err_cnt[i]), 64'(m_cnt[i]));
   endtask

   task automatic tick();
      if (m_grant >= 0) begin
         logic [1:0] gi;
         gi = 2'(m_grant);
         m_vld = 1; m_last = m_grant; m_unit = m_grant; m_code = int'(code[gi]);
         m_addr = addr[gi]; m_meta = meta[gi][0]; m_ovf = ovf[gi];
         if (m_cnt[m_grant] < (1 << CW) - 1) m_cnt[m_grant]++;
      end else if (m_vld && rpt_ready_i) begin
         m_vld = 0;
      end
      if (cnt_clear_i) for (int i = 0; i < N; i++) m_cnt[i] = 0;
      @(negedge clk_i);
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   // Asserts reset at the current time (mid-cycle) and releases it on a falling edge.
   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 64'(rpt_valid), 64'd0);
      chk("rst_irq", 64'(irq_o), 64'd0);
      chk("rst_unit", 64'(rpt_unit), 64'd0);
      chk("rst_addr", 64'(rpt_addr), 64'd0);
      chk("rst_cnt", 64'(err_cnt), 64'd0);
      irq = '1; enable_i = 1'b1;
      repeat (2) begin
         @(negedge clk_i); #2;
         chk("rst_pop", 64'(pop), 64'd0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      irq = '0;
   endtask

   initial begin
      rst_ni = 1'b0; enable_i = 1'b1; rpt_ready_i = 1'b0; cnt_clear_i = 1'b0;
      irq = '0; ovf = '0; code = '0; addr = '0; meta = '0;
      model_reset();
      @(negedge clk_i);
      #2;
      do_reset();

      // Single error from unit 2.
      irq = 4'b0100; code[2] = 3'b101; addr[2] = 48'h1234;
      settle(); chk("single_pop", 64'(pop), 64'h4); tick();
      irq = '0;
      settle();
      chk("single_vld", 64'(rpt_valid), 64'd1);
      chk("single_unit", 64'(rpt_unit), 64'd2);
      chk("single_code", 64'(rpt_code), 64'd5);
      chk("single_addr", 64'(rpt_addr), 64'h1234);
      chk("single_cnt", 64'(err_cnt[2]), 64'd1);
      tick();
      rpt_ready_i = 1'b1; cycle();

      // Fairness with every unit pending.
      #2; do_reset();
      irq = 4'b1111; rpt_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         settle(); chk("fair", 64'(pop), 64'(1 << (k % 4))); tick();
      end
      irq = '0; cycle();

      // Backpressure with units 0 and 1 pending.
      #2; do_reset();
      irq = 4'b0011; rpt_ready_i = 1'b0;
      settle(); chk("bp_pop0", 64'(pop), 64'h1); tick();
      irq = 4'b0010;
      repeat (5) begin
         settle();
         chk("bp_nopop", 64'(pop), 64'd0);
         chk("bp_hold", 64'(rpt_unit), 64'd0);
         tick();
      end
      rpt_ready_i = 1'b1;
      settle(); chk("bp_pop1", 64'(pop), 64'h2); chk("bp_hs", 64'(rpt_valid), 64'd1); tick();
      irq = '0;
      settle(); chk("bp_unit1", 64'(rpt_unit), 64'd1); tick();

      // Counter saturation, then clear coinciding with a pop.
      #2; do_reset();
      irq = 4'b0001; rpt_ready_i = 1'b1;
      repeat (5) cycle();
      irq = '0;
      settle(); chk("sat", 64'(err_cnt[0]), 64'd3); tick();
      irq = 4'b0001; cnt_clear_i = 1'b1;
      cycle();
      irq = '0; cnt_clear_i = 1'b0;
      settle(); chk("clr", 64'(err_cnt[0]), 64'd0); tick();

      // Disable while a report is pending.
      #2; do_reset();
      irq = 4'b0001; rpt_ready_i = 1'b0;
      cycle();
      enable_i = 1'b0; irq = 4'b1111;
      settle(); chk("en_hold", 64'(rpt_valid), 64'd1); tick();
      rpt_ready_i = 1'b1;
      settle(); chk("en_nopop", 64'(pop), 64'd0); tick();
      repeat (2) begin
         settle();
         chk("en_idle", 64'(rpt_valid), 64'd0);
         chk("en_idle_pop", 64'(pop), 64'd0);
         tick();
      end
      enable_i = 1'b1;

      // Reset while a report is held.
      irq = 4'b0100; rpt_ready_i = 1'b0;
      cycle();
      irq = '0;
      settle(); chk("rv_pre", 64'(rpt_valid), 64'd1);
      do_reset();
      irq = 4'b0110; rpt_ready_i = 1'b1;
      settle(); chk("rv_first", 64'(pop), 64'h2); tick();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         enable_i    = ($urandom_range(0, 9) != 0);
         rpt_ready_i = ($urandom_range(0, 2) != 0);
         cnt_clear_i = ($urandom_range(0, 19) == 0);
         irq         = 4'($urandom);
         for (int u = 0; u < N; u++) begin
            code[u] = 3'($urandom);
            addr[u] = 48'({$urandom(), $urandom()});
            meta[u] = 1'($urandom);
            ovf[u]  = 1'($urandom);
         end
         if (i == 300) begin
            #2; do_reset();
         end else begin
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
